// File: rtl/mem_miss_arbiter.sv
// mem_miss_arbiter: collects I$ and D$ miss requests and sends them one at a
// time to a single memory port, choosing between the two caches in turn when
// both are waiting. Each cache can have one outstanding miss.
// The memory response is steered back to the cache that made the request.
// A watchdog turns a response that never arrives into a bus-error response.
// Optional feature: define MEM_ARB_PERF_EN to add saturating perf counters.
module mem_miss_arbiter #(
  parameter int TIMEOUT_CYCLES     = 256,
  parameter int CNT_WIDTH          = 16,
  parameter int REQ_WIDTH          = 64,
  parameter int THR_PER_CORE_WIDTH = 2,
  parameter int DCACHE_LINE_WIDTH  = 512
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ic_req_valid,
  input  logic [REQ_WIDTH-1:0]          ic_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] ic_thread_id,
  input  logic                          dc_req_valid,
  input  logic [REQ_WIDTH-1:0]          dc_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] dc_thread_id,
  output logic                          mem_req_valid,
  output logic [REQ_WIDTH-1:0]          mem_req_info,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0]  mem_rsp_data,
  input  logic                          mem_rsp_error,
  output logic                          ic_rsp_valid,
  output logic                          dc_rsp_valid,
  output logic [DCACHE_LINE_WIDTH-1:0]  rsp_data,
  output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
  output logic                          rsp_bus_error,
`ifdef MEM_ARB_PERF_EN
  output logic [CNT_WIDTH-1:0]          perf_ic_reqs,
  output logic [CNT_WIDTH-1:0]          perf_dc_reqs,
  output logic [CNT_WIDTH-1:0]          perf_timeouts,
  output logic [CNT_WIDTH-1:0]          perf_wait_cycles,
`endif
  output logic                          ovr_ic,
  output logic                          ovr_dc
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                          state_reg;
  logic                            pending_ic_reg, pending_dc_reg;
  logic [REQ_WIDTH-1:0]            ic_info_reg, dc_info_reg;
  logic [THR_PER_CORE_WIDTH-1:0]   ic_thr_reg, dc_thr_reg;
  logic                            rr_dc_reg;     // 1: D$ wins the next tie
  logic                            grant_dc_reg;  // source of the in-flight access
  logic [CNT_WIDTH-1:0]            wd_cnt_reg;

  logic free_ic, free_dc, pick_dc, timeout_hit;

  // The granted source's slot frees in the RESP cycle; a new miss may refill it on the same edge.
  assign free_ic     = (state_reg == ST_RESP) && !grant_dc_reg;
  assign free_dc     = (state_reg == ST_RESP) &&  grant_dc_reg;
  assign pick_dc     = pending_dc_reg && (!pending_ic_reg || rr_dc_reg);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt_reg == WD_LIMIT);

  // Capture one outstanding miss per source; drop (and flag) a pulse while the slot is busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_ic_reg <= 1'b0;
      pending_dc_reg <= 1'b0;
      ic_info_reg    <= '0;
      dc_info_reg    <= '0;
      ic_thr_reg     <= '0;
      dc_thr_reg     <= '0;
      ovr_ic         <= 1'b0;
      ovr_dc         <= 1'b0;
    end else begin
      if (ic_req_valid && (!pending_ic_reg || free_ic)) begin
        ic_info_reg    <= ic_req_info;
        ic_thr_reg     <= ic_thread_id;
        pending_ic_reg <= 1'b1;
      end else begin
        if (free_ic)      pending_ic_reg <= 1'b0;
        if (ic_req_valid) ovr_ic         <= 1'b1;
      end
      if (dc_req_valid && (!pending_dc_reg || free_dc)) begin
        dc_info_reg    <= dc_req_info;
        dc_thr_reg     <= dc_thread_id;
        pending_dc_reg <= 1'b1;
      end else begin
        if (free_dc)      pending_dc_reg <= 1'b0;
        if (dc_req_valid) ovr_dc         <= 1'b1;
      end
    end
  end

  // Arbitration / issue / wait / respond sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rr_dc_reg     <= 1'b1;
      grant_dc_reg  <= 1'b0;
      wd_cnt_reg    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_info  <= '0;
      ic_rsp_valid  <= 1'b0;
      dc_rsp_valid  <= 1'b0;
      rsp_data      <= '0;
      rsp_thread_id <= '0;
      rsp_bus_error <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pending_ic_reg || pending_dc_reg) begin
            if (pending_ic_reg && pending_dc_reg) rr_dc_reg <= !rr_dc_reg;
            grant_dc_reg  <= pick_dc;
            mem_req_valid <= 1'b1;
            mem_req_info  <= pick_dc ? dc_info_reg : ic_info_reg;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wd_cnt_reg    <= '0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid || timeout_hit) begin
            rsp_data      <= mem_rsp_valid ? mem_rsp_data : '0;
            rsp_bus_error <= mem_rsp_valid ? mem_rsp_error : 1'b1;
            rsp_thread_id <= grant_dc_reg ? dc_thr_reg : ic_thr_reg;
            ic_rsp_valid  <= !grant_dc_reg;
            dc_rsp_valid  <= grant_dc_reg;
            state_reg     <= ST_RESP;
          end else if (wd_cnt_reg != '1) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        default: begin
          ic_rsp_valid  <= 1'b0;
          dc_rsp_valid  <= 1'b0;
          rsp_bus_error <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_ic_reqs     <= '0;
      perf_dc_reqs     <= '0;
      perf_timeouts    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state_reg == ST_ISSUE && mem_req_ready) begin
        if (!grant_dc_reg && perf_ic_reqs != '1) perf_ic_reqs <= perf_ic_reqs + 1'b1;
        if (grant_dc_reg && perf_dc_reqs != '1)  perf_dc_reqs <= perf_dc_reqs + 1'b1;
      end
      if (state_reg == ST_WAIT && !mem_rsp_valid && timeout_hit && perf_timeouts != '1)
        perf_timeouts <= perf_timeouts + 1'b1;
      if ((state_reg == ST_ISSUE || state_reg == ST_WAIT) && perf_wait_cycles != '1)
        perf_wait_cycles <= perf_wait_cycles + 1'b1;
    end
  end
`endif

endmodule
